booth_control_fsm: RTL and testbench



---
 rtl/booth_control_fsm.sv | 160 ++++++++++++++++
 tb/tb_booth_control_fsm.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/booth_control_fsm.sv
// ============================================================================
// Module   : booth_control_fsm
// Brief    : Moore sequencer for a radix-2 Booth multiplier (8-bit operands,
//            8 iterations). It drives the control strobes c0..c6 and stop.
//            State encoding is either 3-bit binary or 8-bit one-hot (ONE_HOT).
//            Optional macro BOOTH_CU_DBG_EN adds the state_dbg output, which
//            gives the binary index of the current state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_control_fsm #(
    parameter int ONE_HOT = 0
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       bgn,
    input  logic       q0,
    input  logic       q_1,
    input  logic       count7,
    output logic       c0,
    output logic       c1,
    output logic       c2,
    output logic       c3,
    output logic       c4,
    output logic       c5,
    output logic       c6,
    output logic       stop
`ifdef BOOTH_CU_DBG_EN
    ,
    output logic [2:0] state_dbg
`endif
);

    // Logical state index. The physical register encoding is separate.
    typedef enum logic [2:0] {
        S0 = 3'd0,  // idle
        S1 = 3'd1,  // init: load M and Q, clear A, q_1 and counter
        S2 = 3'd2,  // decide from {q0,q_1}
        S3 = 3'd3,  // add
        S4 = 3'd4,  // subtract
        S5 = 3'd5,  // shift and count
        S6 = 3'd6,  // unload A
        S7 = 3'd7   // unload Q, stop
    } state_t;

    localparam int c_state_w = (ONE_HOT != 0) ? 8 : 3;
    localparam logic [c_state_w-1:0] c_s0_code =
        (ONE_HOT != 0) ? c_state_w'(1) : '0;

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_nxt;
    state_t               w_cur;
    state_t               w_nxt;
    logic                 w_legal;

    generate
        if (ONE_HOT != 0) begin : g_onehot
            // Decode one-hot to an index. Any code without exactly one bit set is illegal.
            always_comb begin
                w_cur   = S0;
                w_legal = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    if (r_state == (c_state_w'(1) << i)) begin
                        w_cur   = state_t'(3'(i));
                        w_legal = 1'b1;
                    end
                end
            end

            // Encode the next index as one-hot.
            always_comb begin
                w_state_nxt = c_state_w'(1) << w_nxt;
            end
        end else begin : g_binary
            // All eight binary codes are used, so the decode is always legal.
            always_comb begin
                w_cur       = state_t'(r_state);
                w_legal     = 1'b1;
                w_state_nxt = w_nxt;
            end
        end
    endgenerate

    // State register. Asynchronous reset aborts any operation immediately.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            r_state <= c_s0_code;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and Moore output decode. An illegal code returns to S0 with quiet outputs.
    always_comb begin
        w_nxt = S0;
        c0    = 1'b0;
        c1    = 1'b0;
        c2    = 1'b0;
        c3    = 1'b0;
        c4    = 1'b0;
        c5    = 1'b0;
        c6    = 1'b0;
        stop  = 1'b0;
        if (w_legal) begin
            case (w_cur)
                S0: begin
                    w_nxt = bgn ? S1 : S0;
                end
                S1: begin
                    c0    = 1'b1;
                    c1    = 1'b1;
                    w_nxt = S2;
                end
                S2: begin
                    case ({q0, q_1})
                        2'b01:   w_nxt = S3;
                        2'b10:   w_nxt = S4;
                        default: w_nxt = S5;
                    endcase
                end
                S3: begin
                    c2    = 1'b1;
                    w_nxt = S5;
                end
                S4: begin
                    c2    = 1'b1;
                    c3    = 1'b1;
                    w_nxt = S5;
                end
                S5: begin
                    c4    = 1'b1;
                    w_nxt = count7 ? S6 : S2;
                end
                S6: begin
                    c5    = 1'b1;
                    w_nxt = S7;
                end
                S7: begin
                    c6    = 1'b1;
                    stop  = 1'b1;
                    w_nxt = bgn ? S7 : S0;
                end
                default: begin
                    w_nxt = S0;
                end
            endcase
        end
    end

`ifdef BOOTH_CU_DBG_EN
    // Binary state index for debug, reported the same way for either encoding.
    always_comb begin
        state_dbg = w_legal ? w_cur : 3'd0;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_booth_control_fsm.sv
`default_nettype none

module tb_booth_control_fsm;

    logic clk = 1'b0;
    logic rst_b;
    logic bgn;
    logic q0;
    logic q_1;
    logic count7;

    // Output vectors packed as {stop,c6,c5,c4,c3,c2,c1,c0}
    wire [7:0] o0;
    wire [7:0] o1;
`ifdef BOOTH_CU_DBG_EN
    wire [2:0] d0;
    wire [2:0] d1;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] outs;
        logic       b;
        logic       qa;
        logic       qb;
        logic       c7;
        logic [2:0] st;
    } step_t;

    step_t tr[$];

    booth_control_fsm #(.ONE_HOT(0)) u_bin (
        .clk(clk), .rst_b(rst_b), .bgn(bgn), .q0(q0), .q_1(q_1), .count7(count7),
        .c0(o0[0]), .c1(o0[1]), .c2(o0[2]), .c3(o0[3]), .c4(o0[4]),
        .c5(o0[5]), .c6(o0[6]), .stop(o0[7])
`ifdef BOOTH_CU_DBG_EN
        , .state_dbg(d0)
`endif
    );

    booth_control_fsm #(.ONE_HOT(1)) u_oh (
        .clk(clk), .rst_b(rst_b), .bgn(bgn), .q0(q0), .q_1(q_1), .count7(count7),
        .c0(o1[0]), .c1(o1[1]), .c2(o1[2]), .c3(o1[3]), .c4(o1[4]),
        .c5(o1[5]), .c6(o1[6]), .stop(o1[7])
`ifdef BOOTH_CU_DBG_EN
        , .state_dbg(d1)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] exp, input logic [2:0] st);
        chk({tag, " bin"}, o0, exp);
        chk({tag, " oh"}, o1, exp);
`ifdef BOOTH_CU_DBG_EN
        chk({tag, " dbg_bin"}, {5'd0, d0}, {5'd0, st});
        chk({tag, " dbg_oh"}, {5'd0, d1}, {5'd0, st});
`endif
    endtask

    function automatic step_t mk(input logic [7:0] outs, input logic [2:0] st);
        step_t s;
        s.outs = outs;
        s.st   = st;
        s.b    = 1'($urandom);
        s.qa   = 1'($urandom);
        s.qb   = 1'($urandom);
        s.c7   = 1'($urandom);
        return s;
    endfunction

    // One multiplication as an expected cycle trace. Mode: 0 random pairs,
    // 1 all skip (00/11), 2 all add/sub (01/10).
    task automatic run_op(input int id, input int mode);
        step_t s;
        logic [1:0] p;
        int nas;
        int lat;
        int exp_lat;
        tr.delete();
        nas = 0;
        s = mk(8'h00, 3'd0); s.b = 1'b1; tr.push_back(s);
        s = mk(8'h03, 3'd1); tr.push_back(s);
        for (int i = 0; i < 8; i++) begin
            p = 2'($urandom);
            if (mode == 1) p = p[0] ? 2'b11 : 2'b00;
            if (mode == 2) p = p[0] ? 2'b10 : 2'b01;
            s = mk(8'h00, 3'd2); s.qa = p[1]; s.qb = p[0]; tr.push_back(s);
            if (p == 2'b01) begin s = mk(8'h04, 3'd3); tr.push_back(s); nas++; end
            if (p == 2'b10) begin s = mk(8'h0C, 3'd4); tr.push_back(s); nas++; end
            s = mk(8'h10, 3'd5); s.c7 = (i == 7); tr.push_back(s);
        end
        s = mk(8'h20, 3'd6); tr.push_back(s);
        for (int h = 0; h < 3; h++) begin
            s = mk(8'hC0, 3'd7); s.b = 1'b1; tr.push_back(s);
        end
        s = mk(8'hC0, 3'd7); s.b = 1'b0; tr.push_back(s);
        s = mk(8'h00, 3'd0); s.b = 1'b0; tr.push_back(s);
        // bgn cycle + S1 + 8 x (S2,S5) + one per add/sub + S6 + first S7 cycle
        exp_lat = 4 + 16 + nas;
        lat = 0;
        for (int k = 0; k < tr.size(); k++) begin
            chk_all($sformatf("run%0d step%0d", id, k), tr[k].outs, tr[k].st);
            if (o0[7] && lat == 0) lat = k + 1;
            bgn    = tr[k].b;
            q0     = tr[k].qa;
            q_1    = tr[k].qb;
            count7 = tr[k].c7;
            @(negedge clk);
        end
        chk($sformatf("run%0d latency", id), 8'(lat), 8'(exp_lat));
    endtask

    initial begin
        rst_b = 1'b1; bgn = 1'b0; q0 = 1'b0; q_1 = 1'b0; count7 = 1'b0;
        repeat (2) @(negedge clk);
        chk_all("reset", 8'h00, 3'd0);
        rst_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            q0 = 1'($urandom); q_1 = 1'($urandom); count7 = 1'($urandom);
            @(negedge clk);
            chk_all($sformatf("idle%0d", i), 8'h00, 3'd0);
        end

        run_op(0, 1);
        run_op(1, 2);
        for (int r = 2; r < 8; r++) run_op(r, 0);

        // Reset asserted while in S4 must silence outputs at once; no shift follows.
        bgn = 1'b1; count7 = 1'b0;
        @(negedge clk);
        chk_all("abort S1", 8'h03, 3'd1);
        bgn = 1'b0; q0 = 1'b1; q_1 = 1'b0;
        @(negedge clk);
        chk_all("abort S2", 8'h00, 3'd2);
        @(negedge clk);
        chk_all("abort S4", 8'h0C, 3'd4);
        rst_b = 1'b1;
        #1;
        chk_all("abort async", 8'h00, 3'd0);
        @(negedge clk);
        chk_all("abort held", 8'h00, 3'd0);
        rst_b = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_all($sformatf("abort after%0d", i), 8'h00, 3'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
